// File: rtl/router_fsm_pkg.sv
// Shared definitions for the 1x3 router packet controller.
// Holds the controller state encoding and the address-field constants
// used by router_fsm and by anything that decodes its state.
package router_fsm_pkg;

  localparam int ADDR_W = 2;
  localparam int NUM_PORTS = 3;
  localparam logic [ADDR_W-1:0] ADDR_INVALID = 2'd3;

  // All eight 3-bit codes are assigned, so every value the register can
  // hold decodes to a named state.
  typedef enum logic [2:0] {
    DECODE_ADDRESS     = 3'd0,
    LOAD_FIRST_DATA    = 3'd1,
    LOAD_DATA          = 3'd2,
    LOAD_PARITY        = 3'd3,
    FIFO_FULL_STATE    = 3'd4,
    LOAD_AFTER_FULL    = 3'd5,
    WAIT_TILL_EMPTY    = 3'd6,
    CHECK_PARITY_ERROR = 3'd7
  } state_t;

  // True when the header address selects one of the real output ports.
  function automatic logic addr_is_valid(input logic [ADDR_W-1:0] a);
    return (a != ADDR_INVALID);
  endfunction

endpackage

// File: rtl/router_fsm.sv
// Purpose: packet-level controller for the 1x3 router; decodes the header
//   address and sequences router_reg through header/payload/parity phases.
// Latency: header accepted -> first payload write 1 cycle; pkt_valid fall ->
//   rst_int_reg 2 cycles. Backpressure: busy holds the source byte whenever
//   the controller is not in DECODE_ADDRESS or LOAD_DATA.
//
// Ports:
//   clock, resetn                 rising-edge clock, async active-low reset
//   pkt_valid, data_in[1:0]       source byte valid and header address field
//   parity_done, low_pkt_valid    status from router_reg
//   fifo_full                     selected-FIFO full, from router_sync
//   fifo_empty_0/1/2              per-FIFO empty
//   soft_reset_0/1/2              per-FIFO timeout reset, from router_sync
//   detect_add .. full_state      one-hot state indications (Moore)
//   write_enb_reg, rst_int_reg    datapath controls (Moore)
//   busy                          stall request to the source
//   addr[1:0]                     latched destination address
module router_fsm
  import router_fsm_pkg::*;
(
  input  logic              clock,
  input  logic              resetn,
  input  logic              pkt_valid,
  input  logic [ADDR_W-1:0] data_in,
  input  logic              parity_done,
  input  logic              low_pkt_valid,
  input  logic              fifo_full,
  input  logic              fifo_empty_0,
  input  logic              fifo_empty_1,
  input  logic              fifo_empty_2,
  input  logic              soft_reset_0,
  input  logic              soft_reset_1,
  input  logic              soft_reset_2,
  output logic              detect_add,
  output logic              lfd_state,
  output logic              ld_state,
  output logic              laf_state,
  output logic              full_state,
  output logic              write_enb_reg,
  output logic              rst_int_reg,
  output logic              busy,
  output logic [ADDR_W-1:0] addr
);

  state_t            state;
  state_t            state_nxt;
  logic [ADDR_W-1:0] sel;
  logic              empty_sel;
  logic              srst_sel;
  logic              hdr_ok;

  // While decoding, the incoming header picks the port; afterwards the
  // latched address does, so a soft reset on another port is ignored.
  always_comb begin
    sel = (state == DECODE_ADDRESS) ? data_in : addr;
  end

  always_comb begin
    empty_sel = 1'b0;
    srst_sel  = 1'b0;
    case (sel)
      2'd0: begin
        empty_sel = fifo_empty_0;
        srst_sel  = soft_reset_0;
      end
      2'd1: begin
        empty_sel = fifo_empty_1;
        srst_sel  = soft_reset_1;
      end
      2'd2: begin
        empty_sel = fifo_empty_2;
        srst_sel  = soft_reset_2;
      end
      default: begin
        empty_sel = 1'b0;
        srst_sel  = 1'b0;
      end
    endcase
  end

  always_comb begin
    hdr_ok = pkt_valid & addr_is_valid(data_in);
  end

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      state <= DECODE_ADDRESS;
    end else begin
      state <= state_nxt;
    end
  end

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      addr <= '0;
    end else if ((state == DECODE_ADDRESS) && hdr_ok) begin
      addr <= data_in;
    end
  end

  always_comb begin
    state_nxt = state;
    // A timeout on the active port abandons the packet from any phase.
    if ((state != DECODE_ADDRESS) && srst_sel) begin
      state_nxt = DECODE_ADDRESS;
    end else begin
      case (state)
        DECODE_ADDRESS: begin
          if (hdr_ok) begin
            state_nxt = empty_sel ? LOAD_FIRST_DATA : WAIT_TILL_EMPTY;
          end
        end
        WAIT_TILL_EMPTY: begin
          if (empty_sel) begin
            state_nxt = LOAD_FIRST_DATA;
          end
        end
        LOAD_FIRST_DATA: begin
          state_nxt = LOAD_DATA;
        end
        LOAD_DATA: begin
          // Full wins over pkt_valid falling; the parity byte is then
          // recovered through low_pkt_valid in LOAD_AFTER_FULL.
          if (fifo_full) begin
            state_nxt = FIFO_FULL_STATE;
          end else if (!pkt_valid) begin
            state_nxt = LOAD_PARITY;
          end
        end
        FIFO_FULL_STATE: begin
          if (!fifo_full) begin
            state_nxt = LOAD_AFTER_FULL;
          end
        end
        LOAD_AFTER_FULL: begin
          if (parity_done) begin
            state_nxt = DECODE_ADDRESS;
          end else if (low_pkt_valid) begin
            state_nxt = LOAD_PARITY;
          end else begin
            state_nxt = LOAD_DATA;
          end
        end
        LOAD_PARITY: begin
          state_nxt = CHECK_PARITY_ERROR;
        end
        CHECK_PARITY_ERROR: begin
          state_nxt = fifo_full ? FIFO_FULL_STATE : DECODE_ADDRESS;
        end
        default: begin
          state_nxt = DECODE_ADDRESS;
        end
      endcase
    end
  end

  // Moore outputs, decoded purely from the state register.
  always_comb begin
    detect_add    = (state == DECODE_ADDRESS);
    lfd_state     = (state == LOAD_FIRST_DATA);
    ld_state      = (state == LOAD_DATA);
    laf_state     = (state == LOAD_AFTER_FULL);
    full_state    = (state == FIFO_FULL_STATE);
    write_enb_reg = (state == LOAD_DATA) || (state == LOAD_PARITY) ||
                    (state == LOAD_AFTER_FULL);
    rst_int_reg   = (state == CHECK_PARITY_ERROR);
    busy          = !((state == DECODE_ADDRESS) || (state == LOAD_DATA));
  end

endmodule

// File: tb/tb_router_fsm.sv
// Bench for router_fsm: directed scenarios followed by random traffic, every
// cycle compared against a phase-level reference of the packet protocol.
module tb_router_fsm;

  logic       clock;
  logic       resetn;
  logic       pkt_valid;
  logic [1:0] data_in;
  logic       parity_done;
  logic       low_pkt_valid;
  logic       fifo_full;
  logic [2:0] empty;
  logic [2:0] srst;
  logic       detect_add, lfd_state, ld_state, laf_state, full_state;
  logic       write_enb_reg, rst_int_reg, busy;
  logic [1:0] addr;

  int n_cmp = 0;
  int n_bad = 0;

  router_fsm dut (
    .clock         (clock),
    .resetn        (resetn),
    .pkt_valid     (pkt_valid),
    .data_in       (data_in),
    .parity_done   (parity_done),
    .low_pkt_valid (low_pkt_valid),
    .fifo_full     (fifo_full),
    .fifo_empty_0  (empty[0]),
    .fifo_empty_1  (empty[1]),
    .fifo_empty_2  (empty[2]),
    .soft_reset_0  (srst[0]),
    .soft_reset_1  (srst[1]),
    .soft_reset_2  (srst[2]),
    .detect_add    (detect_add),
    .lfd_state     (lfd_state),
    .ld_state      (ld_state),
    .laf_state     (laf_state),
    .full_state    (full_state),
    .write_enb_reg (write_enb_reg),
    .rst_int_reg   (rst_int_reg),
    .busy          (busy),
    .addr          (addr)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Reference phases, named after the packet protocol (own numbering).
  localparam int P_IDLE = 0, P_WAIT = 1, P_HDR = 2, P_PAY = 3, P_STALL = 4,
                 P_RESUME = 5, P_PAR = 6, P_CHK = 7;

  int         m_ph;
  logic [1:0] m_addr;

  // Expected {detect,lfd,ld,laf,full,wen,rst_int,busy,addr}
  function automatic logic [9:0] expect_vec(input int ph, input logic [1:0] a);
    logic [7:0] f;
    case (ph)
      P_IDLE:   f = 8'b1000_0000;
      P_WAIT:   f = 8'b0000_0001;
      P_HDR:    f = 8'b0100_0001;
      P_PAY:    f = 8'b0010_0100;
      P_STALL:  f = 8'b0000_1001;
      P_RESUME: f = 8'b0001_0101;
      P_PAR:    f = 8'b0000_0101;
      default:  f = 8'b0000_0011;
    endcase
    return {f, a};
  endfunction

  function automatic logic [9:0] dut_vec();
    return {detect_add, lfd_state, ld_state, laf_state, full_state,
            write_enb_reg, rst_int_reg, busy, addr};
  endfunction

  task automatic check(input string tag, input logic [9:0] obs, input logic [9:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  // Apply inputs, advance the reference by the protocol rules, clock, compare.
  task automatic cyc(input string tag, input logic pv, input logic [1:0] din,
                     input logic pd, input logic lpv, input logic ff,
                     input logic [2:0] emp, input logic [2:0] sr);
    int port;
    int nph;
    logic e, s;
    pkt_valid = pv; data_in = din; parity_done = pd; low_pkt_valid = lpv;
    fifo_full = ff; empty = emp; srst = sr;
    port = (m_ph == P_IDLE) ? int'(din) : int'(m_addr);
    e = (port < 3) ? emp[port] : 1'b0;
    s = (port < 3) ? sr[port] : 1'b0;
    nph = m_ph;
    if (m_ph != P_IDLE && s) nph = P_IDLE;
    else begin
      case (m_ph)
        P_IDLE:   if (pv && din != 2'd3) nph = e ? P_HDR : P_WAIT;
        P_WAIT:   if (e) nph = P_HDR;
        P_HDR:    nph = P_PAY;
        P_PAY:    nph = ff ? P_STALL : (!pv ? P_PAR : P_PAY);
        P_STALL:  if (!ff) nph = P_RESUME;
        P_RESUME: nph = pd ? P_IDLE : (lpv ? P_PAR : P_PAY);
        P_PAR:    nph = P_CHK;
        default:  nph = ff ? P_STALL : P_IDLE;
      endcase
    end
    if (m_ph == P_IDLE && pv && din != 2'd3) m_addr = din;
    @(posedge clock);
    #1;
    m_ph = nph;
    check(tag, dut_vec(), expect_vec(m_ph, m_addr));
  endtask

  task automatic do_reset(input string tag);
    resetn = 1'b0;
    #2;
    m_ph = P_IDLE; m_addr = 2'd0;
    check(tag, dut_vec(), expect_vec(P_IDLE, 2'd0));
    resetn = 1'b1;
  endtask

  int pulses;

  initial begin
    resetn = 1'b1; pkt_valid = 1'b1; data_in = 2'd1; parity_done = 1'b0;
    low_pkt_valid = 1'b0; fifo_full = 1'b0; empty = 3'b111; srst = 3'b000;
    m_ph = P_IDLE; m_addr = 2'd0;
    #1;
    // Reset with live stimulus, checked between clock edges.
    do_reset("reset_async");
    resetn = 1'b0;
    @(posedge clock); #1;
    check("reset_held", dut_vec(), 10'b1000_0000_00);
    resetn = 1'b1;

    // Normal packet to port 1.
    pulses = 0;
    for (int i = 0; i < 6; i++) cyc("pkt1_body", 1'b1, 2'd1, 1'b0, 1'b0, 1'b0, 3'b010, 3'b000);
    for (int i = 0; i < 3; i++) begin
      cyc("pkt1_tail", 1'b0, 2'd1, 1'b0, 1'b0, 1'b0, 3'b010, 3'b000);
      if (rst_int_reg) pulses++;
    end
    check("pkt1_rst_int_pulses", 10'(pulses), 10'd1);
    check("pkt1_done", dut_vec(), 10'b1000_0000_01);

    // Busy destination 2, empties at cycle 10.
    for (int i = 0; i < 10; i++) cyc("wait_empty", 1'b1, 2'd2, 1'b0, 1'b0, 1'b0, 3'b000, 3'b000);
    check("wait_busy", dut_vec(), 10'b0000_0001_10);
    cyc("wait_to_lfd", 1'b1, 2'd2, 1'b0, 1'b0, 1'b0, 3'b100, 3'b000);
    check("lfd_reached", dut_vec(), 10'b0100_0001_10);
    cyc("to_ld", 1'b1, 2'd2, 1'b0, 1'b0, 1'b0, 3'b100, 3'b000);

    // Full stall for 4 cycles, then resume to LOAD_DATA.
    for (int i = 0; i < 4; i++) cyc("full_stall", 1'b1, 2'd2, 1'b0, 1'b0, 1'b1, 3'b100, 3'b000);
    check("full_state_busy", dut_vec(), 10'b0000_1001_10);
    cyc("full_release", 1'b1, 2'd2, 1'b0, 1'b0, 1'b0, 3'b100, 3'b000);
    cyc("laf_to_ld", 1'b1, 2'd2, 1'b0, 1'b0, 1'b0, 3'b100, 3'b000);
    check("back_in_ld", dut_vec(), 10'b0010_0100_10);
    // Full coincident with pkt_valid falling; parity via low_pkt_valid.
    cyc("full_and_fall", 1'b0, 2'd2, 1'b0, 1'b0, 1'b1, 3'b100, 3'b000);
    cyc("full_release2", 1'b0, 2'd2, 1'b0, 1'b1, 1'b0, 3'b100, 3'b000);
    cyc("laf_to_par", 1'b0, 2'd2, 1'b0, 1'b1, 1'b0, 3'b100, 3'b000);
    check("par_reached", dut_vec(), 10'b0000_0101_10);
    cyc("par_to_chk", 1'b0, 2'd2, 1'b0, 1'b0, 1'b0, 3'b100, 3'b000);
    cyc("chk_to_idle", 1'b0, 2'd2, 1'b0, 1'b0, 1'b0, 3'b100, 3'b000);

    // Soft reset in WAIT_TILL_EMPTY with addr=0.
    cyc("to_wait0", 1'b1, 2'd0, 1'b0, 1'b0, 1'b0, 3'b000, 3'b000);
    cyc("srst_other", 1'b1, 2'd0, 1'b0, 1'b0, 1'b0, 3'b000, 3'b100);
    check("srst_other_ignored", dut_vec(), 10'b0000_0001_00);
    cyc("srst_own", 1'b0, 2'd0, 1'b0, 1'b0, 1'b0, 3'b000, 3'b001);
    check("srst_own_idle", dut_vec(), 10'b1000_0000_00);

    // Invalid address dropped, addr retained.
    cyc("set_addr1", 1'b1, 2'd1, 1'b0, 1'b0, 1'b0, 3'b000, 3'b000);
    cyc("srst1", 1'b0, 2'd1, 1'b0, 1'b0, 1'b0, 3'b000, 3'b010);
    for (int i = 0; i < 5; i++) cyc("invalid_addr", 1'b1, 2'd3, 1'b0, 1'b0, 1'b0, 3'b111, 3'b000);
    check("invalid_stays", dut_vec(), 10'b1000_0000_01);

    // Random traffic with occasional mid-packet resets.
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 199) == 0) begin
        do_reset("rand_reset");
      end else begin
        cyc("random",
            1'($urandom_range(0, 9) < 7), 2'($urandom_range(0, 3)),
            1'($urandom_range(0, 3) == 0), 1'($urandom_range(0, 2) == 0),
            1'($urandom_range(0, 4) == 0), 3'($urandom_range(0, 7)),
            3'(($urandom_range(0, 15) == 0) ? $urandom_range(1, 7) : 0));
      end
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/router_fsm.md
Name: router_fsm

Overview:
Packet-level controller for the 1x3 router.
- Decodes the 2-bit destination address on the first byte of a packet.
- Sequences the register block through header, payload, parity and parity-check phases.
- Stalls the source with busy while the destination FIFO is not ready.
- Sits between the input port and the router_reg / router_sync datapath; router_sync supplies its empty/full/soft_reset status.

Parameters:
none; 3 destination ports are fixed by the router topology.

Ports:
clock  input  1  system clock, rising edge
resetn  input  1  asynchronous active-low reset
pkt_valid  input  1  source byte valid; deasserts on the parity byte
data_in  input  2  address field of the header byte (0,1,2 valid; 3 invalid)
parity_done  input  1  router_reg has captured the parity byte
low_pkt_valid  input  1  router_reg saw pkt_valid fall while stalled
fifo_full  input  1  selected-FIFO full, from router_sync
fifo_empty_0/1/2  input  1 each  per-FIFO empty
soft_reset_0/1/2  input  1 each  per-FIFO timeout reset, from router_sync
detect_add  output  1  in DECODE_ADDRESS
lfd_state  output  1  in LOAD_FIRST_DATA
ld_state  output  1  in LOAD_DATA
laf_state  output  1  in LOAD_AFTER_FULL
full_state  output  1  in FIFO_FULL_STATE
write_enb_reg  output  1  register block may write the FIFO
rst_int_reg  output  1  clear internal parity-error logic
busy  output  1  source must hold its current byte
addr  output  2  latched destination address

Behaviour:
- One state register, encoded in the shared package. Moore outputs only, decoded from the state.
- Reset (resetn=0, asynchronous) sets state=DECODE_ADDRESS and addr=0.
  - Outputs during reset: detect_add=1; all other 1-bit outputs 0; addr=0.
- Decoded outputs:
  - write_enb_reg = LOAD_DATA | LOAD_PARITY | LOAD_AFTER_FULL.
  - rst_int_reg = CHECK_PARITY_ERROR.
  - busy = 1 in every state except DECODE_ADDRESS and LOAD_DATA.
- addr capture: in DECODE_ADDRESS, when pkt_valid=1 and data_in!=3, addr<=data_in. addr holds in all other states.
- Address-matched signals: empty_sel = fifo_empty_[addr], srst_sel = soft_reset_[addr]. In DECODE_ADDRESS both use data_in instead of addr.
- Soft reset has highest priority: srst_sel=1 in any state except DECODE_ADDRESS -> DECODE_ADDRESS on the next edge.
- Transitions (evaluated at each rising edge):
  - DECODE_ADDRESS: pkt_valid & data_in!=3 & empty_sel -> LOAD_FIRST_DATA. pkt_valid & data_in!=3 & !empty_sel -> WAIT_TILL_EMPTY. Otherwise stay; data_in=3 is dropped and the state stays.
  - WAIT_TILL_EMPTY: empty_sel -> LOAD_FIRST_DATA; else stay.
  - LOAD_FIRST_DATA -> LOAD_DATA unconditionally (1 cycle; header written).
  - LOAD_DATA: fifo_full -> FIFO_FULL_STATE. Else !pkt_valid -> LOAD_PARITY. Else stay. fifo_full has priority when both are true.
  - FIFO_FULL_STATE: !fifo_full -> LOAD_AFTER_FULL; else stay.
  - LOAD_AFTER_FULL: parity_done -> DECODE_ADDRESS. Else low_pkt_valid -> LOAD_PARITY. Else LOAD_DATA.
  - LOAD_PARITY -> CHECK_PARITY_ERROR unconditionally.
  - CHECK_PARITY_ERROR: fifo_full -> FIFO_FULL_STATE; else DECODE_ADDRESS.
- Latency:
  - Header accepted to first payload write: 1 cycle (LOAD_FIRST_DATA).
  - pkt_valid fall to rst_int_reg: 2 cycles.
- Simultaneous events:
  - soft_reset for an address other than addr is ignored.
  - fifo_full and pkt_valid falling together in LOAD_DATA -> FIFO_FULL_STATE; parity is recovered via low_pkt_valid.
- Reset mid-packet aborts immediately. No state survives except what the datapath holds.
- Illegal or unused state encodings -> DECODE_ADDRESS on the next edge.

Decomposition:
- router_pkg:
  - state enum (8 states, 3 bits);
  - ADDR_W=2;
  - ADDR_INVALID=2'd3;
  - NUM_PORTS=3.
- Single module; no sub-module. The per-address empty/soft_reset mux is inline.

Test Plan:
- Reset: resetn=0 with stimulus active -> detect_add=1, busy=0, addr=0, all other outputs 0. Holds mid-cycle without a clock edge.
- Normal packet to port 1, fifo_empty_1=1:
  - data_in=1, pkt_valid=1 for 6 cycles, then 0.
  - States go DECODE -> LFD -> LD x5 -> LOAD_PARITY -> CHECK_PARITY_ERROR -> DECODE.
  - rst_int_reg pulses for 1 cycle; addr=1.
- Busy destination, data_in=2 with fifo_empty_2=0:
  - WAIT_TILL_EMPTY, busy=1 held.
  - fifo_empty_2 rises at cycle 10 -> LOAD_FIRST_DATA next edge.
- Full stall, fifo_full=1 in LOAD_DATA for 4 cycles:
  - full_state=1 and busy=1 for those cycles, then LOAD_AFTER_FULL.
  - With parity_done=0, low_pkt_valid=0 -> back to LOAD_DATA.
  - Repeat with low_pkt_valid=1 -> LOAD_PARITY.
- Soft reset while in WAIT_TILL_EMPTY with addr=0:
  - soft_reset_0=1 -> DECODE_ADDRESS next edge.
  - soft_reset_2=1 instead -> no effect.
- Invalid address, data_in=3, pkt_valid=1 for 5 cycles -> stays in DECODE_ADDRESS, busy=0, addr unchanged.
